boot_sequencer: RTL and testbench
=================================

// Module: boot_sequencer
// PURPOSE
// - Sequences MIPS_core bring-up in hardware, replacing testbench hierarchical preloads.
// - After reset: holds the core in reset, zero-fills instruction and data memory, then
//   accepts a program word stream into instruction memory, then releases the core.
// - Sits beside MIPS_core and drives the IMEM/DMEM write ports; a reload request re-runs the sequence.
// PARAMETERS
// - IMEM_DEPTH  512   instruction memory words; IMEM_AW = $clog2(IMEM_DEPTH)
// - DMEM_DEPTH  1024  data memory words (set to `DATA_MEM_DEPTH); DMEM_AW = $clog2(DMEM_DEPTH)
// PORTS
// - clk         in   1        system clock, rising edge
// - rst         in   1        asynchronous, active-low reset
// - ld_valid    in   1        program word valid
// - ld_data     in   32       program word
// - ld_last     in   1        qualifies final word of the program
// - ld_ready    out  1        sequencer accepts a word this cycle
// - reload      in   1        1-cycle pulse in RUN/ERR: restart the whole sequence
// - imem_we     out  1        instruction memory write enable
// - imem_addr   out  IMEM_AW  instruction memory word address
// - imem_wdata  out  32       instruction memory write data
// - dmem_we     out  1        data memory write enable
// - dmem_addr   out  DMEM_AW  data memory word address
// - dmem_wdata  out  32       data memory write data (always 0)
// - core_rst    out  1        active-high reset to MIPS_core
// - boot_done   out  1        core released, program running
// - boot_err    out  1        load failed; core held in reset
// - load_count  out  IMEM_AW+1  words written in the last/current load
// BEHAVIOUR
// - All outputs registered. Reset values: core_rst=1, all others 0; state=CLEAR, counters=0.
// - States: CLEAR -> LOAD -> RUN; LOAD -> ERR; RUN/ERR -> CLEAR on reload.
// - CLEAR: counter c walks 0..max(IMEM_DEPTH,DMEM_DEPTH)-1, one address per cycle.
//   imem_we=1 only while c<IMEM_DEPTH, dmem_we=1 only while c<DMEM_DEPTH, wdata=0.
//   First write is presented the cycle after rst deasserts; the cycle after the last address -> LOAD.
// - LOAD: ld_ready=1. A word transfers when ld_valid&&ld_ready. On the next cycle it
//   appears on imem_we/imem_addr=load_addr/imem_wdata; load_addr and load_count then increment.
//   ld_valid low: no write, no state change (no timeout).
// - Transfer with ld_last=1 -> RUN; ld_ready drops the following cycle.
// - Overflow: a transfer at load_addr=IMEM_DEPTH-1 without ld_last is written, then -> ERR.
// - Zero-length program is impossible; minimum is one word carrying ld_last.
// - RUN: core_rst=0 and boot_done=1 starting the cycle after the last word's write cycle.
//   No memory writes; ld_ready=0.
// - ERR: boot_err=1, core_rst=1, ld_ready=0, no writes.
// - reload in RUN/ERR: next cycle core_rst=1, boot_done=0, boot_err=0, counters=0, state CLEAR.
//   Ignored in CLEAR/LOAD.
// - rst asserted at any time: immediate return to reset values. A partial load is discarded
//   and fully re-cleared.
// - Memory-port contract: imem_we and dmem_we are never asserted while core_rst=0.
// CONFIGURATION
// - BOOT_CHECKSUM_EN defined: adds input ld_csum[31:0], sampled with the ld_last transfer.
//   The sequencer keeps a modulo-2^32 running sum of accepted words, including the last word.
//   Match -> RUN; mismatch -> ERR (the last word is still written). The sum clears in CLEAR.
// - BOOT_CHECKSUM_EN undefined: no ld_csum port, no adder; ld_last always -> RUN.
// TESTING
// - Reset release, IMEM_DEPTH=8, DMEM_DEPTH=16 -> 16 clear cycles, imem_we for c=0..7
//   only, dmem_we for c=0..15; first LOAD-state ld_ready at cycle 17.
// - Load 20010001, 200f000f, 08100009 (last) with a 1-cycle ld_valid gap -> imem[0..2]
//   written in order; load_count=3; core_rst=0 and boot_done=1 the cycle after the third write.
// - IMEM_DEPTH=8: 8 words without ld_last -> all 8 written, then boot_err=1, core_rst=1.
// - In RUN, pulse reload -> core_rst=1 next cycle, full clear re-run, second load of 1 word -> RUN.
// - rst asserted mid-LOAD after 2 words -> outputs return to reset values; after release,
//   clear restarts from c=0.
// - BOOT_CHECKSUM_EN: words 1,2,3 with ld_csum=6 -> RUN; repeat with ld_csum=7 -> ERR.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot sequencer for MIPS_core: holds the core in reset, zero-fills IMEM/DMEM, streams a
// program into IMEM, then releases the core. Optional BOOT_CHECKSUM_EN adds a load checksum.

`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 1024
`endif

module boot_sequencer #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = `DATA_MEM_DEPTH,
  localparam int IMEM_AW = $clog2(IMEM_DEPTH),
  localparam int DMEM_AW = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
`ifdef BOOT_CHECKSUM_EN
  input  logic [31:0]        ld_csum,
`endif
  output logic               ld_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               core_rst,
  output logic               boot_done,
  output logic               boot_err,
  output logic [IMEM_AW:0]   load_count
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam int MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
  localparam int CW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  localparam logic [CW:0]        IMEM_END  = (CW+1)'(IMEM_DEPTH);
  localparam logic [CW:0]        DMEM_END  = (CW+1)'(DMEM_DEPTH);
  localparam logic [CW-1:0]      C_LAST    = CW'(MAX_DEPTH - 1);
  localparam logic [IMEM_AW-1:0] ADDR_LAST = IMEM_AW'(IMEM_DEPTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      c;
  logic [IMEM_AW-1:0] load_addr;
  logic               xfer;
  logic               csum_ok;

  assign xfer       = ld_valid && ld_ready;
  assign dmem_wdata = '0;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_acc;

  // The final word is part of the sum, so compare against the post-add value.
  assign csum_ok = ((csum_acc + ld_data) == ld_csum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_acc <= '0;
    end else if (state == S_CLEAR) begin
      csum_acc <= '0;
    end else if (state == S_LOAD && xfer) begin
      csum_acc <= csum_acc + ld_data;
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_CLEAR;
      c          <= '0;
      load_addr  <= '0;
      load_count <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      core_rst   <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block
      // override the defaults below within the same clock edge.
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      ld_ready <= 1'b0;

      case (state)
        S_CLEAR: begin
          imem_we    <= ({1'b0, c} < IMEM_END);
          dmem_we    <= ({1'b0, c} < DMEM_END);
          imem_addr  <= c[IMEM_AW-1:0];
          dmem_addr  <= c[DMEM_AW-1:0];
          imem_wdata <= '0;
          if (c == C_LAST) begin
            c     <= '0;
            state <= S_LOAD;
          end else begin
            c <= c + 1'b1;
          end
        end

        S_LOAD: begin
          ld_ready <= 1'b1;
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= load_addr;
            imem_wdata <= ld_data;
            load_addr  <= load_addr + 1'b1;
            load_count <= load_count + 1'b1;
            if (ld_last) begin
              ld_ready <= 1'b0;
              state    <= csum_ok ? S_RUN : S_ERR;
            end else if (load_addr == ADDR_LAST) begin
              // Program does not fit: the last slot is still written before failing.
              ld_ready <= 1'b0;
              state    <= S_ERR;
            end
          end
        end

        S_RUN: begin
          core_rst  <= 1'b0;
          boot_done <= 1'b1;
        end

        default: begin
          core_rst <= 1'b1;
          boot_err <= 1'b1;
        end
      endcase

      if (reload && (state == S_RUN || state == S_ERR)) begin
        state      <= S_CLEAR;
        c          <= '0;
        load_addr  <= '0;
        load_count <= '0;
        core_rst   <= 1'b1;
        boot_done  <= 1'b0;
        boot_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer (IMEM_DEPTH=8, DMEM_DEPTH=16); expected IMEM
// writes are queued as stimulus is driven and compared when the DUT writes.

module tb_boot_sequencer;

  localparam int IMEM_DEPTH = 8;
  localparam int DMEM_DEPTH = 16;
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               ld_valid;
  logic [31:0]        ld_data;
  logic               ld_last;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]        ld_csum;
`endif
  logic               ld_ready;
  logic               reload;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               core_rst;
  logic               boot_done;
  logic               boot_err;
  logic [IMEM_AW:0]   load_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  int  exp_addr = 0;
  int  dmem_exp = 0;
  int  dmem_cnt = 0;

  boot_sequencer #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
`ifdef BOOT_CHECKSUM_EN
    .ld_csum    (ld_csum),
`endif
    .ld_ready   (ld_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .core_rst   (core_rst),
    .boot_done  (boot_done),
    .boot_err   (boot_err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    if (imem_we === 1'b1 || dmem_we === 1'b1) check("we_while_core_running", core_rst, 1);
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("imem_unexpected_we", imem_we, 0);
      end else begin
        w = exp_q.pop_front();
        check("imem_addr", {{(32-IMEM_AW){1'b0}}, imem_addr}, w.a);
        check("imem_wdata", imem_wdata, w.d);
      end
    end
    if (dmem_we === 1'b1) begin
      check("dmem_addr", {{(32-DMEM_AW){1'b0}}, dmem_addr}, dmem_exp);
      check("dmem_wdata", dmem_wdata, 0);
      dmem_exp++;
      dmem_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_boot_done"}, boot_done, 0);
    check({tag, "_boot_err"}, boot_err, 0);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_dmem_we"}, dmem_we, 0);
    check({tag, "_load_count"}, load_count, 0);
  endtask

  task automatic start_clear();
    for (int i = 0; i < IMEM_DEPTH; i++) exp_q.push_back('{a: i, d: 32'h0});
    dmem_exp = 0;
    dmem_cnt = 0;
    exp_addr = 0;
  endtask

  // Counts edges from the first clear cycle until ld_ready is seen.
  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ld_ready !== 1'b1 && n < 100);
    check({tag, "_ready_cycle"}, n, 17);
    check({tag, "_dmem_writes"}, dmem_cnt, DMEM_DEPTH);
    check({tag, "_imem_pending"}, exp_q.size(), 0);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [31:0] cs);
    int n = 0;
    while (ld_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ld_ready", ld_ready, 1);
    if (ld_ready === 1'b1) begin
      exp_q.push_back('{a: exp_addr, d: d});
      exp_addr++;
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
`ifdef BOOT_CHECKSUM_EN
    ld_csum  = cs;
`endif
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic expect_run(input int cnt, input string tag);
    check({tag, "_last_we"}, imem_we, 1);
    check({tag, "_last_core_rst"}, core_rst, 1);
    check({tag, "_last_ld_ready"}, ld_ready, 0);
    @(posedge clk); #1;
    check({tag, "_run_core_rst"}, core_rst, 0);
    check({tag, "_run_boot_done"}, boot_done, 1);
    check({tag, "_run_load_count"}, load_count, cnt);
    check({tag, "_run_ld_ready"}, ld_ready, 0);
    check({tag, "_run_imem_we"}, imem_we, 0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_boot_done"}, boot_done, 0);
    check({tag, "_boot_err"}, boot_err, 0);
    check({tag, "_load_count"}, load_count, 0);
    start_clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    ld_csum  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    // Clear after reset release, then a three-word program with a one-cycle gap.
    rst = 1'b1;
    start_clear();
    wait_ready("clear1");
    send(32'h2001_0001, 1'b0, 32'h0);
    @(posedge clk); #1;
    send(32'h200f_000f, 1'b0, 32'h0);
    send(32'h0810_0009, 1'b1, 32'h0);
    expect_run(3, "load1");

    // Reload from RUN, one-word program.
    do_reload("reload1");
    wait_ready("clear2");
    send(32'h2402_0005, 1'b1, 32'h0);
    expect_run(1, "load2");

    // Overflow: eight words without ld_last; reload is ignored mid-LOAD.
    do_reload("reload2");
    wait_ready("clear3");
    send(32'h0000_0100, 1'b0, 32'h0);
    send(32'h0000_0101, 1'b0, 32'h0);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_ignored_ld_ready", ld_ready, 1);
    check("reload_ignored_load_count", load_count, 2);
    check("reload_ignored_core_rst", core_rst, 1);
    for (int i = 2; i < IMEM_DEPTH; i++) send(32'h0000_0100 + i, 1'b0, 32'h0);
    check("ovf_last_we", imem_we, 1);
    check("ovf_last_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("ovf_boot_err", boot_err, 1);
    check("ovf_core_rst", core_rst, 1);
    check("ovf_boot_done", boot_done, 0);
    check("ovf_load_count", load_count, IMEM_DEPTH);
    check("ovf_ld_ready", ld_ready, 0);
    ld_valid = 1'b1;
    ld_data  = 32'hdead_beef;
    repeat (3) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    check("err_no_write", imem_we, 0);
    check("err_hold_boot_err", boot_err, 1);

    // Asynchronous reset in the middle of a load.
    do_reload("reload3");
    wait_ready("clear4");
    send(32'h0000_0200, 1'b0, 32'h0);
    send(32'h0000_0201, 1'b0, 32'h0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset("midload_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    start_clear();
    wait_ready("clear5");
    send(32'h0000_0300, 1'b1, 32'h0);
    expect_run(1, "load5");

`ifdef BOOT_CHECKSUM_EN
    do_reload("reload4");
    wait_ready("clear6");
    send(32'd1, 1'b0, 32'h0);
    send(32'd2, 1'b0, 32'h0);
    send(32'd3, 1'b1, 32'd6);
    expect_run(3, "csum_match");

    do_reload("reload5");
    wait_ready("clear7");
    send(32'd1, 1'b0, 32'h0);
    send(32'd2, 1'b0, 32'h0);
    send(32'd3, 1'b1, 32'd7);
    check("csum_bad_last_we", imem_we, 1);
    @(posedge clk); #1;
    check("csum_bad_boot_err", boot_err, 1);
    check("csum_bad_core_rst", core_rst, 1);
    check("csum_bad_boot_done", boot_done, 0);
    check("csum_bad_load_count", load_count, 3);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_imem_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
